// File: rtl/wb_pkg.sv
// Shared constants, state encoding and payload type for the write-back sequencer.
package wb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    // RV32 major opcodes that produce a register result
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Load width/sign encodings in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } wb_state_e;

    // Instruction and write data held stable for the register file
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] data;
    } wb_payload_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data alignment: picks byte/halfword at the offset and extends it.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then sign/zero extension by funct3
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            F3_LW:   result = word;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: selects result source, runs the wb/regwr -> wb_comp
// four-phase handshake with the register file, pulses done on retire.
// Define WB_LOAD_EXT_EN to enable sub-word load alignment and extension.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_load,
    input  logic [31:0] in_pc,
    output logic        wb,
    output logic        regwr,
    output logic [31:0] inst,
    output logic [31:0] wrdata,
    input  logic        wb_comp,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    wb_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt, err_nxt;
    logic             wb_q, done_q, err_q;
    wb_payload_t      pay_q;
    logic [31:0]      load_data;
    logic [31:0]      src_data;
    logic             has_wr;
    logic             accept;

`ifdef WB_LOAD_EXT_EN
    wb_load_align u_align (
        .funct3 (in_inst[14:12]),
        .offset (in_alu[1:0]),
        .word   (in_load),
        .result (load_data)
    );
`else
    assign load_data = in_load;
`endif

    // Ready depends on state only; held low while reset is asserted
    assign in_ready = rst && (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Result source select by opcode; rd==x0 suppresses the write
    always_comb begin
        src_data = in_alu;
        has_wr   = 1'b0;
        case (in_inst[6:0])
            OPC_LUI: begin
                src_data = {in_inst[31:12], 12'h000};
                has_wr   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                src_data = in_pc + 32'd4;
                has_wr   = 1'b1;
            end
            OPC_LOAD: begin
                src_data = load_data;
                has_wr   = 1'b1;
            end
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                src_data = in_alu;
                has_wr   = 1'b1;
            end
            default: has_wr = 1'b0;
        endcase
        if (in_inst[11:7] == 5'd0) begin
            has_wr = 1'b0;
        end
    end

    // Next-state, phase timeout and retire/error decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    if (has_wr) begin
                        state_nxt = WRITE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wb_comp) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!wb_comp) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wb_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wb_q   <= (state_nxt == WRITE);
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    // Payload captured on every accept, held until the next one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pay_q <= '0;
        end else if (accept) begin
            pay_q.inst <= in_inst;
            pay_q.data <= src_data;
        end
    end

    assign wb     = wb_q;
    assign regwr  = wb_q;
    assign done   = done_q;
    assign err    = err_q;
    assign inst   = pay_q.inst;
    assign wrdata = pay_q.data;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer with a simple register-file responder.
module tb_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst, in_alu, in_load, in_pc;
    logic        wb, regwr;
    logic [31:0] inst, wrdata;
    logic        wb_comp = 1'b0;
    logic        done, err;
    logic        rf_en;

    int nvec = 0;
    int nerr = 0;

    wb_sequencer #(.TIMEOUT_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_alu   (in_alu),
        .in_load  (in_load),
        .in_pc    (in_pc),
        .wb       (wb),
        .regwr    (regwr),
        .inst     (inst),
        .wrdata   (wrdata),
        .wb_comp  (wb_comp),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Register file: acknowledges one cycle after seeing wb, releases one cycle after wb drops
    always @(posedge clk) wb_comp <= rf_en & wb;

    logic [2:0]  ld_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  ld_off [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] ld_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
`else
    logic [31:0] ld_exp [4] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {17'h0, f3, rd, opc};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] l, input logic [31:0] p);
        in_inst  = i;
        in_alu   = a;
        in_load  = l;
        in_pc    = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts wb-high cycles and the cycle index (0 = after accept edge) of done; -1 if none
    task automatic run_write(output int wbc, output int done_at);
        wbc     = 0;
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (wb) wbc++;
            if (done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int wbc, dat;
        logic saw_wb;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        in_alu   = '0;
        in_load  = '0;
        in_pc    = '0;
        rf_en    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wb",     32'(wb),       32'd0);
        chk("rst_regwr",  32'(regwr),    32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_err",    32'(err),      32'd0);
        chk("rst_inst",   inst,          32'd0);
        chk("rst_wrdata", wrdata,        32'd0);
        rst = 1'b1;
        #1;
        chk("rst_ready",  32'(in_ready), 32'd1);
        @(negedge clk);

        // LUI x5, 0x12345
        issue({20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'h0, 32'h0);
        chk("lui_wb",     32'(wb),       32'd1);
        chk("lui_regwr",  32'(regwr),    32'd1);
        chk("lui_ready",  32'(in_ready), 32'd0);
        chk("lui_wrdata", wrdata,        32'h12345000);
        chk("lui_rd",     32'(inst[11:7]), 32'd5);
        run_write(wbc, dat);
        chk("lui_wbcyc",  32'(wbc),      32'd2);
        chk("lui_done",   32'(dat),      32'd4);
        chk("lui_ready2", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("lui_pulse",  32'(done),     32'd0);

        // Loads with alignment/extension
        for (int n = 0; n < 4; n++) begin
            issue(mk(ld_f3[n], 5'd6, 7'b0000011), 32'h1000 | 32'(ld_off[n]), 32'h80FF7F01, 32'h0);
            chk($sformatf("ld%0d_data", n), wrdata, ld_exp[n]);
            run_write(wbc, dat);
            chk($sformatf("ld%0d_done", n), 32'(dat), 32'd4);
        end

        // JAL wraps, JALR
        issue(mk(3'b000, 5'd1, 7'b1101111), 32'h0, 32'h0, 32'hFFFFFFFC);
        chk("jal_wrap", wrdata, 32'h00000000);
        run_write(wbc, dat);
        chk("jal_done", 32'(dat), 32'd4);
        issue(mk(3'b000, 5'd1, 7'b1100111), 32'h0, 32'h0, 32'h00000100);
        chk("jalr_data", wrdata, 32'h00000104);
        run_write(wbc, dat);
        chk("jalr_done", 32'(dat), 32'd4);

        // SW, BEQ, ADDI x0 back-to-back: one done per cycle, no write
        in_valid = 1'b1;
        in_inst  = mk(3'b010, 5'd3, 7'b0100011);
        @(negedge clk);
        chk("nw0_done",  32'(done),     32'd1);
        chk("nw0_ready", 32'(in_ready), 32'd1);
        chk("nw0_wb",    32'(wb),       32'd0);
        in_inst = mk(3'b000, 5'd4, 7'b1100011);
        @(negedge clk);
        chk("nw1_done",  32'(done),     32'd1);
        chk("nw1_wb",    32'(wb),       32'd0);
        in_inst = mk(3'b000, 5'd0, 7'b0010011);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nw2_done",  32'(done),     32'd1);
        chk("nw2_wb",    32'(wb),       32'd0);
        chk("nw2_inst",  inst,          mk(3'b000, 5'd0, 7'b0010011));
        @(negedge clk);
        chk("nw3_done",  32'(done),     32'd0);

        // Timeout: no acknowledge
        rf_en = 1'b0;
        issue(mk(3'b000, 5'd2, 7'b0110011), 32'h55, 32'h0, 32'h0);
        saw_wb = 1'b0;
        dat    = -1;
        for (int k = 0; k < 8; k++) begin
            if (!wb) saw_wb = 1'b1;
            if (done) dat = k;
            if (k == 7) chk("to_err_pre", 32'(err), 32'd0);
            @(negedge clk);
        end
        chk("to_wb_held", 32'(saw_wb),   32'd0);
        chk("to_err",     32'(err),      32'd1);
        chk("to_wb",      32'(wb),       32'd0);
        chk("to_regwr",   32'(regwr),    32'd0);
        chk("to_ready",   32'(in_ready), 32'd1);
        if (done) dat = 8;
        chk("to_nodone",  32'(dat),      32'hFFFFFFFF);
        rf_en = 1'b1;
        @(negedge clk);
        chk("to_nodone2", 32'(done),     32'd0);
        issue({20'h0ABCD, 5'd7, 7'b0110111}, 32'h0, 32'h0, 32'h0);
        run_write(wbc, dat);
        chk("to_next_done", 32'(dat),  32'd4);
        chk("to_next_data", wrdata,    32'h0ABCD000);
        chk("to_err_stick", 32'(err),  32'd1);

        // Async reset in the middle of WRITE
        issue(mk(3'b000, 5'd8, 7'b0110011), 32'h1234, 32'h0, 32'h0);
        @(negedge clk);
        chk("mid_wb_pre", 32'(wb), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_wb",    32'(wb),    32'd0);
        chk("mid_regwr", 32'(regwr), 32'd0);
        chk("mid_done",  32'(done),  32'd0);
        chk("mid_err",   32'(err),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(mk(3'b000, 5'd4, 7'b0110011), 32'hDEADBEEF, 32'h0, 32'h0);
        chk("add_data", wrdata, 32'hDEADBEEF);
        run_write(wbc, dat);
        chk("add_done", 32'(dat), 32'd4);
        chk("add_wbc",  32'(wbc), 32'd2);
        chk("add_err",  32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back stage controller that drives the register file's write port. It accepts one retiring instruction and its candidate results over a valid/ready handshake, and selects the write data from LUI immediate, ALU result, PC+4 or aligned load data. It then runs a four-phase wb/regwr → wb_comp handshake with the register file and pulses `done` to the core control FSM once the write is acknowledged.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 8: cycles allowed per handshake phase before abort; legal range 2..255.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  retiring instruction present.
- `in_ready`  out  1  sequencer can accept; high only in IDLE.
- `in_inst`  in  32  instruction word.
- `in_alu`  in  32  ALU result / effective load address.
- `in_load`  in  32  raw data-memory word.
- `in_pc`  in  32  PC of the instruction.
- `wb`  out  1  write-back phase active, to register file.
- `regwr`  out  1  write enable, to register file.
- `inst`  out  32  latched instruction; register file takes rd from [11:7].
- `wrdata`  out  32  latched write data.
- `wb_comp`  in  1  register-file write acknowledge.
- `done`  out  1  one-cycle pulse: instruction retired.
- `err`  out  1  sticky: handshake timeout occurred.

## Operation
- Reset: all outputs 0, except `in_ready`, which is 1 once `rst` deasserts. State is IDLE and the timeout counter is 0.
- Accept happens on `in_valid & in_ready`. At the accepting edge, `inst` and `wrdata` are latched and stay stable until the next accept.
- Source select by opcode:
  - LUI 0110111: {inst[31:12],12'b0}.
  - JAL 1101111 / JALR 1100111: in_pc+4, mod 2^32.
  - LOAD 0000011: aligned load data.
  - OP 0110011, OP-IMM 0010011, AUIPC 0010111: in_alu.
  - All other opcodes, or rd==0: no-write.
- No-write instruction: stays in IDLE, `done`=1 in the next cycle, `wb`/`regwr` never asserted.
- Write instruction state machine:
  - IDLE → WRITE: `wb`=`regwr`=1.
  - WRITE, on `wb_comp`=1 → RELEASE: `wb`=`regwr`=0.
  - RELEASE, on `wb_comp`=0 → IDLE, with registered `done`=1 for one cycle.
- Load alignment by funct3, with byte offset in_alu[1:0]:
  - LB 000: byte at offset, sign-extended.
  - LBU 100: byte at offset, zero-extended.
  - LH 001: halfword selected by in_alu[1], sign-extended; in_alu[0] ignored.
  - LHU 101: same selection, zero-extended.
  - LW 010 and undefined codes: full word.
- Timeout:
  - The counter clears on every state entry and increments each cycle in WRITE or RELEASE.
  - Reaching TIMEOUT_CYC forces IDLE, `wb`=`regwr`=0, `err`=1. `done` is not pulsed.
  - `err` is cleared only by reset.
- `wb_comp` is ignored in IDLE.

## Timing
- Write path, with accept at edge E0:
  - `wb` high after E0.
  - The register file writes at E1 and raises `wb_comp` after E1.
  - At E2 the sequencer enters RELEASE and `wb` drops.
  - `wb_comp` falls after E3.
  - At E4 the sequencer is in IDLE: `done`=1 and `in_ready`=1 during the cycle after E4.
  - Minimum 4 cycles accept-to-done.
- No-write path: `done` in the cycle after accept. `in_ready` stays high, so back-to-back accepts take 1 per cycle.
- `in_ready` is combinational from state only, never from `in_valid`.
- Async reset mid-handshake: `wb`, `regwr`, `done` go to 0 immediately and the state returns to IDLE. The register file may hold a stale `wb_comp`; IDLE ignores it.

## Configuration
- `WB_LOAD_EXT_EN` defined: sub-word load alignment and extension as specified above.
- Undefined: every LOAD writes in_load unmodified, regardless of funct3 and offset. The alignment sub-module is not instantiated.

## Structure
- Package `wb_pkg`:
  - opcode constants: LUI, AUIPC, JAL, JALR, LOAD, OP, OP_IMM.
  - load funct3 constants.
  - state enum IDLE/WRITE/RELEASE.
- Sub-module `wb_load_align`: combinational; inputs funct3, offset[1:0], word; output the 32-bit result.

## Test plan
- LUI x5 with imm 0x12345 → `wrdata`=0x12345000 and `inst`[11:7]=5. `wb`/`regwr` high for 2 cycles; `done` 4 cycles after accept.
- LOAD, in_load=0x80FF7F01:
  - LB at offset 3 → 0xFFFFFF80.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
  - LHU at offset 0 → 0x00007F01.
  - Without `WB_LOAD_EXT_EN`, all of the above → 0x80FF7F01.
- JAL with in_pc=0xFFFFFFFC → `wrdata`=0x00000000 (wrap-around). JALR with in_pc=0x100 → 0x104.
- SW, BEQ and ADDI x0 issued back-to-back → three `done` pulses on consecutive cycles, `wb` never high.
- `wb_comp` held 0 with default TIMEOUT_CYC → `err`=1 after 8 cycles in WRITE. `wb` drops, `in_ready`=1, no `done`, and the next instruction completes normally with `err` still 1.
- `rst` low in the middle of WRITE → `wb`=`regwr`=`done`=`err`=0 immediately. After release, an ADD of in_alu=0xDEADBEEF completes in 4 cycles.
